// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic C;
        logic V;
        logic N;
        logic Z;
    } cla_flags_t;

    function automatic int num_groups(input int width, input int group);
        return width / group;
    endfunction

    // Pipeline stage that resolves lookahead group grp (groups split evenly, low first).
    function automatic int stage_of(input int grp, input int stages, input int ng);
        return ((grp + 1) * stages - 1) / ng;
    endfunction

    function automatic int last_group(input int stage, input int stages, input int ng);
        return ((stage + 1) * ng) / stages - 1;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle; master drives operands and consumes results.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             V;
    logic             N;
    logic             Z;

    modport master (
        output in_valid, op_sub, A, B, C_in, out_ready,
        input  in_ready, out_valid, S, C_out, V, N, Z
    );

    modport slave (
        input  in_valid, op_sub, A, B, C_in, out_ready,
        output in_ready, out_valid, S, C_out, V, N, Z
    );
endinterface

// File: rtl/cla_group.sv
// GROUP-bit lookahead block: local sum plus group generate/propagate.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             G,
    output logic             P
);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic [GROUP:0]   gg;

    assign g = a & b;
    assign p = a ^ b;

    // gg is the carry chain with zero carry-in, whose top bit is the group generate.
    always_comb begin
        c     = '0;
        gg    = '0;
        c[0]  = c_in;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1]  = g[i] | (p[i] & c[i]);
            gg[i+1] = g[i] | (p[i] & gg[i]);
        end
    end

    assign s = p ^ c[GROUP-1:0];
    assign G = gg[GROUP];
    assign P = &p;
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor; group carries are resolved a slice per stage.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    cla_pipe_adder_if.slave bus
);
    localparam int NG   = num_groups(WIDTH, GROUP);
    localparam int LAST = STAGES - 1;

    if ((WIDTH % GROUP) != 0 || STAGES < 1 || STAGES > NG) begin : g_param_check
        $error("cla_pipe_adder: need WIDTH %% GROUP == 0 and 1 <= STAGES <= WIDTH/GROUP");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] res_c;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  bx_q    [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [WIDTH-1:0]  res_sum [STAGES];
    logic [WIDTH-1:0]  grp_sum;
    logic              in_ready;
    logic              accept;

    // Each group reads the register of the stage that owns it; the first group of a
    // stage takes that stage's pending carry.
    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int ST   = stage_of(k, STAGES, NG);
        localparam bit HEAD = (k == 0) || (stage_of(k - 1, STAGES, NG) != ST);
        logic             cin;
        logic             cout;
        logic             gen;
        logic             prop;
        logic [GROUP-1:0] s;

        if (HEAD) begin : g_head
            assign cin = c_q[ST];
        end else begin : g_chain
            assign cin = g_grp[k-1].cout;
        end

        cla_group #(.GROUP(GROUP)) u_group (
            .a    (a_q[ST][k*GROUP +: GROUP]),
            .b    (bx_q[ST][k*GROUP +: GROUP]),
            .c_in (cin),
            .s    (s),
            .G    (gen),
            .P    (prop)
        );

        assign cout                        = gen | (prop & cin);
        assign grp_sum[k*GROUP +: GROUP]   = s;
    end

    function automatic logic [WIDTH-1:0] stage_mask(input int st);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < NG; k++) begin
            if (stage_of(k, STAGES, NG) == st) m = m | (WIDTH'({GROUP{1'b1}}) << (k * GROUP));
        end
        return m;
    endfunction

    for (genvar st = 0; st < STAGES; st++) begin : g_res
        localparam logic [WIDTH-1:0] MASK = stage_mask(st);
        assign res_sum[st] = (sum_q[st] & ~MASK) | (grp_sum & MASK);
        assign res_c[st]   = g_grp[last_group(st, STAGES, NG)].cout;
    end

    // Backpressure ripples from out_ready toward the input so a full pipe can still stream.
    always_comb begin
        load       = '0;
        load[LAST] = !vld[LAST] || bus.out_ready;
        for (int st = LAST - 1; st >= 0; st--) load[st] = !vld[st] || load[st+1];
    end

    assign in_ready     = !rst && load[0];
    assign accept       = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;

    // Stage boundary: valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            if (load[0]) vld[0] <= accept;
            for (int st = 1; st < STAGES; st++) begin
                if (load[st]) vld[st] <= vld[st-1];
            end
        end
    end

    // Stage boundary: operands, partial sums and pending carry
    always_ff @(posedge clk) begin
        if (load[0]) begin
            a_q[0]   <= bus.A;
            bx_q[0]  <= (bus.op_sub == OP_SUB) ? ~bus.B : bus.B;
            c_q[0]   <= bus.C_in ^ bus.op_sub;
            sum_q[0] <= '0;
        end
        for (int st = 1; st < STAGES; st++) begin
            if (load[st]) begin
                a_q[st]   <= a_q[st-1];
                bx_q[st]  <= bx_q[st-1];
                c_q[st]   <= res_c[st-1];
                sum_q[st] <= res_sum[st-1];
            end
        end
    end

    cla_flags_t       flags;
    logic [WIDTH-1:0] s_out;

    always_comb begin
        s_out   = vld[LAST] ? res_sum[LAST] : '0;
        flags.C = vld[LAST] && res_c[LAST];
        flags.N = s_out[WIDTH-1];
        flags.Z = vld[LAST] && (s_out == '0);
        flags.V = vld[LAST] && (a_q[LAST][WIDTH-1] == bx_q[LAST][WIDTH-1])
                            && (s_out[WIDTH-1] != a_q[LAST][WIDTH-1]);
    end

    assign bus.out_valid = vld[LAST];
    assign bus.S         = s_out;
    assign bus.C_out     = flags.C;
    assign bus.V         = flags.V;
    assign bus.N         = flags.N;
    assign bus.Z         = flags.Z;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed corner vectors, stall, reset and random traffic.
module tb_cla_pipe_adder;
    import cla_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         n;
        logic         z;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   rand_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        exp_t         e;
        int           sa;
        int           sb;
        int           r;
        logic [W:0]   u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub == OP_SUB) begin
            e.s = a - b - W'(cin);
            e.c = ({1'b0, a} >= ({1'b0, b} + (W+1)'(cin)));
            r   = sa - sb - int'(cin);
        end else begin
            u   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            e.s = u[W-1:0];
            e.c = u[W];
            r   = sa + sb + int'(cin);
        end
        e.v = (r > ((1 << (W - 1)) - 1)) || (r < -(1 << (W - 1)));
        e.n = e.s[W-1];
        e.z = (e.s == '0);
        return e;
    endfunction

    task automatic send(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
        bit done;
        done = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_sub   = sub;
        bus.A        = a;
        bus.B        = b;
        bus.C_in     = cin;
        for (int t = 0; t < 200 && !done; t++) begin
            #1;
            if (bus.in_ready && !rst) begin
                q.push_back(model(sub, a, b, cin));
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 for 200 cycles, required 1");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A        = W'($urandom);
        bus.B        = W'($urandom);
        bus.op_sub   = 1'($urandom);
        bus.C_in     = 1'($urandom);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        #4;
        check("drain_queue_left", 32'(q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever a result transfers; checks hold during stalls.
    initial begin : monitor
        logic         stalled;
        logic [W+3:0] held;
        logic [W+3:0] cur;
        exp_t         e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #3;
            cur = {bus.S, bus.C_out, bus.V, bus.N, bus.Z};
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_hold_S_CVNZ", 32'(cur), 32'(held));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got S=0x%0h, required no output", bus.S);
                    end else begin
                        e = q.pop_front();
                        check("result_S_CVNZ", 32'(cur), 32'({e.s, e.c, e.v, e.n, e.z}));
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held    = cur;
            end
        end
    end

    initial begin : main
        bus.in_valid  = 1'b0;
        bus.op_sub    = OP_ADD;
        bus.A         = '0;
        bus.B         = '0;
        bus.C_in      = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        repeat (2) @(negedge clk);
        #2;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_S", 32'(bus.S), 32'd0);
        check("reset_CVNZ", 32'({bus.C_out, bus.V, bus.N, bus.Z}), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        // 6+5 with latency probe
        send(OP_ADD, 16'd6, 16'd5, 1'b0);
        idle();
        #2;
        check("latency_cycle1_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #2;
        check("latency_cycle2_out_valid", 32'(bus.out_valid), 32'd1);
        wait_drain();

        // Corner vectors, back to back
        send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        send(OP_ADD, 16'h000F, 16'h000F, 1'b1);
        send(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        send(OP_SUB, 16'h8000, 16'h0001, 1'b0);
        send(OP_SUB, 16'd5, 16'd5, 1'b0);
        send(OP_SUB, 16'd3, 16'd5, 1'b0);
        send(OP_SUB, 16'd5, 16'd5, 1'b1);
        send(OP_ADD, 16'hFFFF, 16'hFFFF, 1'b1);
        send(OP_SUB, 16'h0000, 16'hFFFF, 1'b1);
        idle();
        wait_drain();

        // Stall on the first result of a back-to-back stream
        fork
            begin
                send(OP_ADD, 16'd500, 16'd500, 1'b0);
                send(OP_ADD, 16'd1, 16'd1, 1'b0);
                send(OP_ADD, 16'd2, 16'd2, 1'b0);
                idle();
            end
            begin
                int t;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!bus.out_valid && t < 50);
                check("stream_first_valid_seen", 32'(bus.out_valid), 32'd1);
                bus.out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #2;
                    check("stall_in_ready_full", 32'(bus.in_ready), 32'd0);
                    check("stall_S_is_1000", 32'(bus.S), 32'd1000);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset one cycle after accepting 7+1
        send(OP_ADD, 16'd7, 16'd1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        q.delete();
        for (int i = 0; i < 2; i++) begin
            #2;
            check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
            check("midreset_S", 32'(bus.S), 32'd0);
            check("midreset_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("post_reset_no_pulse", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        send(OP_ADD, 16'd8, 16'd8, 1'b0);
        idle();
        #2;
        check("post_reset_latency1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #2;
        check("post_reset_latency2", 32'(bus.out_valid), 32'd1);
        check("post_reset_S_16", 32'(bus.S), 32'd16);
        wait_drain();

        // Random traffic with random backpressure
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) idle();
                    send(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
                end
                idle();
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
